// File: rtl/pcap_arming_ctrl_pkg.sv
// pcap_arming_ctrl_pkg: shared PCAP arming state encoding and disarm-reason bit indices
package pcap_arming_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FIFO_RST   = 3'd1,
    WAIT_READY = 3'd2,
    ARMED      = 3'd3,
    ENABLED    = 3'd4,
    DRAIN      = 3'd5
  } state_t;
  localparam int DISARM_SW    = 0;
  localparam int DISARM_ABORT = 1;
  localparam int DISARM_DONE  = 2;
endpackage

// File: rtl/pcap_arming_ctrl.sv
// pcap_arming_ctrl: PCAP arm/run-control FSM with DMA FIFO reset handshake and sticky disarm reason
module pcap_arming_ctrl
  import pcap_arming_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ARM,
  input  logic       DISARM,
  input  logic       enable_i,
  input  logic       abort_i,
  input  logic       ongoing_capture_i,
  output logic       dma_fifo_reset_o,
  input  logic       dma_fifo_ready_i,
  output logic       pcap_armed_o,
  output logic       pcap_enabled_o,
  output logic [2:0] pcap_disarmed_o
);
  state_t     state_q, state_d;
  logic       stop, done, arm_ok;
  logic [2:0] disarmed_d;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      dma_fifo_reset_o <= 1'b0;
      pcap_armed_o     <= 1'b0;
      pcap_enabled_o   <= 1'b0;
      pcap_disarmed_o  <= 3'b000;
    end else begin
      state_q          <= state_d;
      dma_fifo_reset_o <= state_d == FIFO_RST;
      pcap_armed_o     <= state_d == ARMED || state_d == ENABLED || state_d == DRAIN;
      pcap_enabled_o   <= state_d == ENABLED;
      pcap_disarmed_o  <= disarmed_d;
    end
  end
  always_comb begin
    stop    = state_q != IDLE && (DISARM || abort_i);
    arm_ok  = state_q == IDLE && ARM;
    done    = state_q == DRAIN && !ongoing_capture_i && !stop;
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = ARM ? FIFO_RST : IDLE;
      FIFO_RST:   state_d = WAIT_READY;
      WAIT_READY: state_d = dma_fifo_ready_i ? ARMED : WAIT_READY;
      ARMED:      state_d = enable_i ? ENABLED : ARMED;
      ENABLED:    state_d = enable_i ? ENABLED : DRAIN;
      DRAIN:      state_d = ongoing_capture_i ? DRAIN : IDLE;
      default:    state_d = IDLE;
    endcase
    state_d = stop ? IDLE : state_d;
    disarmed_d = pcap_disarmed_o;
    disarmed_d[DISARM_SW]    = pcap_disarmed_o[DISARM_SW] | (stop & DISARM);
    disarmed_d[DISARM_ABORT] = pcap_disarmed_o[DISARM_ABORT] | (stop & abort_i);
    disarmed_d[DISARM_DONE]  = pcap_disarmed_o[DISARM_DONE] | done;
    disarmed_d = arm_ok ? 3'b000 : disarmed_d;
  end
endmodule

// File: tb/tb_pcap_arming_ctrl.sv
// tb_pcap_arming_ctrl: directed self-checking bench for pcap_arming_ctrl
module tb_pcap_arming_ctrl;
  logic       clk_i = 0, reset_i = 1, ARM = 0, DISARM = 0, enable_i = 0, abort_i = 0;
  logic       ongoing_capture_i = 0, dma_fifo_ready_i = 0;
  logic       dma_fifo_reset_o, pcap_armed_o, pcap_enabled_o;
  logic [2:0] pcap_disarmed_o;
  int n_checks = 0, n_fail = 0;
  pcap_arming_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .ARM(ARM), .DISARM(DISARM), .enable_i(enable_i),
    .abort_i(abort_i), .ongoing_capture_i(ongoing_capture_i), .dma_fifo_reset_o(dma_fifo_reset_o),
    .dma_fifo_ready_i(dma_fifo_ready_i), .pcap_armed_o(pcap_armed_o),
    .pcap_enabled_o(pcap_enabled_o), .pcap_disarmed_o(pcap_disarmed_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic f, input logic a, input logic e, input logic [2:0] d);
    check({tag, ".fifo_rst"}, {2'b0, dma_fifo_reset_o}, {2'b0, f});
    check({tag, ".armed"}, {2'b0, pcap_armed_o}, {2'b0, a});
    check({tag, ".enabled"}, {2'b0, pcap_enabled_o}, {2'b0, e});
    check({tag, ".disarmed"}, pcap_disarmed_o, d);
  endtask
  task automatic arm_enable(input string tag);
    enable_i = 0; dma_fifo_ready_i = 1; ongoing_capture_i = 0;
    ARM = 1; tick(); ARM = 0;
    outs({tag, ".fiforst"}, 1, 0, 0, 3'b000);
    tick();
    outs({tag, ".wait"}, 0, 0, 0, 3'b000);
    tick();
    outs({tag, ".armed"}, 0, 1, 0, 3'b000);
    enable_i = 1; tick();
    outs({tag, ".enabled"}, 0, 1, 1, 3'b000);
  endtask
  initial begin
    repeat (10) tick();
    outs("reset", 0, 0, 0, 3'b000);
    reset_i = 0; tick();
    outs("idle", 0, 0, 0, 3'b000);
    ARM = 1; tick(); ARM = 0;
    outs("arm.pulse", 1, 0, 0, 3'b000);
    tick(); tick(); tick();
    outs("arm.wait_ready", 0, 0, 0, 3'b000);
    dma_fifo_ready_i = 1; tick();
    outs("arm.ready", 0, 1, 0, 3'b000);
    enable_i = 1; tick();
    outs("run.enable", 0, 1, 1, 3'b000);
    ARM = 1; tick(); ARM = 0;
    outs("run.arm_ignored", 0, 1, 1, 3'b000);
    ongoing_capture_i = 1; enable_i = 0; tick();
    outs("run.drain", 0, 1, 0, 3'b000);
    tick(); tick();
    outs("run.drain_hold", 0, 1, 0, 3'b000);
    ongoing_capture_i = 0; tick();
    outs("run.done", 0, 0, 0, 3'b100);
    DISARM = 1; abort_i = 1; tick(); DISARM = 0; abort_i = 0;
    outs("idle.disarm_ignored", 0, 0, 0, 3'b100);
    arm_enable("sw");
    DISARM = 1; tick(); DISARM = 0;
    outs("sw.disarm", 0, 0, 0, 3'b001);
    arm_enable("abort");
    abort_i = 1; tick(); abort_i = 0;
    outs("abort.hit", 0, 0, 0, 3'b010);
    arm_enable("both");
    abort_i = 1; DISARM = 1; tick(); abort_i = 0; DISARM = 0;
    outs("both.hit", 0, 0, 0, 3'b011);
    arm_enable("drain_dis");
    ongoing_capture_i = 1; enable_i = 0; tick();
    outs("drain_dis.drain", 0, 1, 0, 3'b000);
    ongoing_capture_i = 0; DISARM = 1; tick(); DISARM = 0;
    outs("drain_dis.prio", 0, 0, 0, 3'b001);
    dma_fifo_ready_i = 0; ARM = 1; tick(); ARM = 0;
    outs("wr_dis.pulse", 1, 0, 0, 3'b000);
    tick();
    DISARM = 1; tick(); DISARM = 0;
    outs("wr_dis.disarm", 0, 0, 0, 3'b001);
    dma_fifo_ready_i = 1; tick(); tick();
    outs("wr_dis.stays_idle", 0, 0, 0, 3'b001);
    ARM = 1; DISARM = 1; tick(); ARM = 0; DISARM = 0;
    outs("arm_dis.arm_wins", 1, 0, 0, 3'b000);
    tick(); tick(); enable_i = 1; tick();
    outs("rst_mid.enabled", 0, 1, 1, 3'b000);
    abort_i = 1; DISARM = 1; tick(); abort_i = 0; DISARM = 0;
    arm_enable("rst_mid2");
    reset_i = 1; tick(); reset_i = 0; enable_i = 0;
    outs("rst_mid.reset", 0, 0, 0, 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
